// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_types_pkg : shared CPU datapath types (word, dcache address)   |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int DC_SETS = 8;
  localparam int DC_IDXW = $clog2(DC_SETS);
  localparam int DC_TAGW = 32 - DC_IDXW - 3;

  typedef struct packed {
    logic [DC_TAGW-1:0] tag;
    logic [DC_IDXW-1:0] idx;
    logic               blkoff;
    logic [1:0]         bytoff;
  } dcache_addr_t;

endpackage
`default_nettype wire

// File: rtl/dcache_snoop_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dcache_snoop_responder : answers bus snoops/invalidates for dcache |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module dcache_snoop_responder
  import cpu_types_pkg::*;
#(
  parameter int SETS = 8,
  parameter int IDXW = $clog2(SETS),
  parameter int TAGW = 32 - IDXW - 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ccwait,
  input  logic            ccinv,
  input  logic [31:0]     ccsnoopaddr,
  input  logic            dwait,
  output logic            ccwrite,
  output logic [31:0]     daddr,
  output logic [31:0]     dstore,
  output logic [IDXW-1:0] lk_index,
  input  logic            lk_valid,
  input  logic            lk_dirty,
  input  logic [TAGW-1:0] lk_tag,
  input  logic [31:0]     lk_data0,
  input  logic [31:0]     lk_data1,
  output logic            upd_en,
  output logic [IDXW-1:0] upd_index,
  output logic            upd_valid,
  output logic            upd_dirty,
  output logic            snoop_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WB0, S_WB1, S_UPD} snoop_state_t;

  snoop_state_t    state_q, state_d;
  logic [TAGW-1:0] tag_q;
  logic [IDXW-1:0] idx_q;
  word_t           data0_q, data1_q;

  logic [TAGW-1:0] snp_tag;
  logic [IDXW-1:0] snp_idx;
  logic            match;
  logic            latch_en;
  logic            unused_offset;

  assign snp_tag       = ccsnoopaddr[31:IDXW+3];
  assign snp_idx       = ccsnoopaddr[IDXW+2:3];
  assign unused_offset = ^ccsnoopaddr[2:0];

  assign lk_index   = (state_q == S_IDLE) ? snp_idx : idx_q;
  assign match      = lk_valid && (lk_tag == snp_tag);
  assign snoop_busy = (state_q != S_IDLE) || ccwait || ccinv;

  always_comb begin
    state_d   = state_q;
    ccwrite   = 1'b0;
    daddr     = '0;
    dstore    = '0;
    upd_en    = 1'b0;
    upd_index = '0;
    upd_valid = 1'b0;
    upd_dirty = 1'b0;
    latch_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Invalidate wins over a concurrent snoop and suppresses ccwrite.
        if (ccinv) begin
          if (match) begin
            upd_en    = 1'b1;
            upd_index = snp_idx;
          end
        end else if (ccwait && match && lk_dirty) begin
          ccwrite  = 1'b1;
          latch_en = 1'b1;
          state_d  = S_WB0;
        end
      end
      S_WB0: begin
        ccwrite = 1'b1;
        daddr   = {tag_q, idx_q, 3'b000};
        dstore  = data0_q;
        if (!dwait) state_d = S_WB1;
      end
      S_WB1: begin
        ccwrite = 1'b1;
        daddr   = {tag_q, idx_q, 3'b100};
        dstore  = data1_q;
        if (!dwait) state_d = S_UPD;
      end
      S_UPD: begin
        // Block is now clean in memory: downgrade M to S.
        ccwrite   = 1'b1;
        upd_en    = 1'b1;
        upd_index = idx_q;
        upd_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        tag_q   <= snp_tag;
        idx_q   <= snp_idx;
        data0_q <= lk_data0;
        data1_q <= lk_data1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_snoop_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dcache_snoop_responder : directed bench with frame-array model  |
// | Revision: 1.0                                                      |
// +------------------------------------------------------------------+
module tb_dcache_snoop_responder;
  import cpu_types_pkg::*;

  localparam int SETS = 8;
  localparam int IDXW = 3;
  localparam int TAGW = 26;

  logic            CLK = 1'b0;
  logic            RST, ccwait, ccinv, dwait;
  logic [31:0]     ccsnoopaddr;
  logic            ccwrite, upd_en, upd_valid, upd_dirty, snoop_busy;
  logic [31:0]     daddr, dstore;
  logic [IDXW-1:0] lk_index, upd_index;
  logic            lk_valid, lk_dirty;
  logic [TAGW-1:0] lk_tag;
  logic [31:0]     lk_data0, lk_data1;

  // Frame array model, written by the DUT update port or a bench preload.
  logic            fv  [SETS] = '{default: 1'b0};
  logic            fd  [SETS] = '{default: 1'b0};
  logic [TAGW-1:0] ft  [SETS] = '{default: '0};
  logic [31:0]     fw0 [SETS] = '{default: '0};
  logic [31:0]     fw1 [SETS] = '{default: '0};

  logic            ld_en = 1'b0;
  logic [IDXW-1:0] ld_idx;
  logic            ld_v, ld_d;
  logic [TAGW-1:0] ld_tag;
  logic [31:0]     ld_w0, ld_w1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  dcache_snoop_responder #(.SETS(SETS)) dut (
    .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .ccwrite(ccwrite),
    .daddr(daddr), .dstore(dstore), .lk_index(lk_index),
    .lk_valid(lk_valid), .lk_dirty(lk_dirty), .lk_tag(lk_tag),
    .lk_data0(lk_data0), .lk_data1(lk_data1), .upd_en(upd_en),
    .upd_index(upd_index), .upd_valid(upd_valid), .upd_dirty(upd_dirty),
    .snoop_busy(snoop_busy)
  );

  always_comb begin
    lk_valid = fv[lk_index];
    lk_dirty = fd[lk_index];
    lk_tag   = ft[lk_index];
    lk_data0 = fw0[lk_index];
    lk_data1 = fw1[lk_index];
  end

  always @(posedge CLK) begin
    if (ld_en) begin
      fv[ld_idx]  <= ld_v;
      fd[ld_idx]  <= ld_d;
      ft[ld_idx]  <= ld_tag;
      fw0[ld_idx] <= ld_w0;
      fw1[ld_idx] <= ld_w1;
    end else if (upd_en) begin
      fv[upd_index] <= upd_valid;
      fd[upd_index] <= upd_dirty;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change here, checks follow #1.
  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic load_frame(input logic v, input logic d, input logic [TAGW-1:0] t);
    cyc();
    ld_en = 1'b1; ld_idx = 3'd2; ld_v = v; ld_d = d; ld_tag = t;
    ld_w0 = 32'hAAAA0000; ld_w1 = 32'hBBBB0001;
    cyc();
    ld_en = 1'b0;
  endtask

  dcache_addr_t hit_a, miss_a;

  initial begin
    hit_a  = '{tag: 26'h1A, idx: 3'd2, blkoff: 1'b0, bytoff: 2'b00};  // 0x690
    miss_a = '{tag: 26'h1B, idx: 3'd2, blkoff: 1'b0, bytoff: 2'b00};  // 0x6D0
    RST = 1'b1; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b1; ccsnoopaddr = '0;
    ld_idx = '0; ld_v = 1'b0; ld_d = 1'b0; ld_tag = '0; ld_w0 = '0; ld_w1 = '0;
    cyc(); cyc(); #1;
    chk("rst_ccwrite", {31'd0, ccwrite}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_upd_en", {31'd0, upd_en}, 32'd0);
    chk("rst_busy", {31'd0, snoop_busy}, 32'd0);
    RST = 1'b0;

    // M hit, memory accepts every cycle.
    load_frame(1'b1, 1'b1, 26'h1A);
    ccwait = 1'b1; ccsnoopaddr = hit_a; dwait = 1'b0; #1;
    chk("m_hit_ccwrite", {31'd0, ccwrite}, 32'd1);
    chk("m_hit_busy", {31'd0, snoop_busy}, 32'd1);
    cyc(); #1;
    chk("wb0_daddr", daddr, 32'h690);
    chk("wb0_dstore", dstore, 32'hAAAA0000);
    cyc(); #1;
    chk("wb1_daddr", daddr, 32'h694);
    chk("wb1_dstore", dstore, 32'hBBBB0001);
    cyc(); #1;
    chk("upd_fields", {26'd0, upd_en, upd_index, upd_valid, upd_dirty}, {26'd0, 1'b1, 3'd2, 1'b1, 1'b0});
    chk("upd_daddr", daddr, 32'd0);
    ccwait = 1'b0;
    cyc(); #1;
    chk("back_idle_busy", {31'd0, snoop_busy}, 32'd0);
    chk("frame_now_s", {30'd0, fv[2], fd[2]}, 32'b10);

    // M hit with dwait high 3 cycles per word.
    load_frame(1'b1, 1'b1, 26'h1A);
    ccwait = 1'b1; dwait = 1'b1; #1;
    chk("slow_hit_ccwrite", {31'd0, ccwrite}, 32'd1);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      dwait = !(k == 4 || k == 8);
      if (k == 9) ccwait = 1'b0;
      #1;
      if (k <= 4) begin
        chk($sformatf("slow_w0_addr_%0d", k), daddr, 32'h690);
        chk($sformatf("slow_w0_data_%0d", k), dstore, 32'hAAAA0000);
      end else if (k <= 8) begin
        chk($sformatf("slow_w1_addr_%0d", k), daddr, 32'h694);
        chk($sformatf("slow_w1_data_%0d", k), dstore, 32'hBBBB0001);
      end
      chk($sformatf("slow_upd_en_%0d", k), {31'd0, upd_en}, {31'd0, k == 9});
    end
    cyc(); #1;
    chk("slow_idle_ccwrite", {31'd0, ccwrite}, 32'd0);

    // S hit, then tag miss, under ccwait.
    ccwait = 1'b1; ccsnoopaddr = hit_a; dwait = 1'b0; #1;
    chk("s_hit_ccwrite", {31'd0, ccwrite}, 32'd0);
    chk("s_hit_busy", {31'd0, snoop_busy}, 32'd1);
    cyc(); #1;
    chk("s_hit_stay_idle", {daddr[31:1], upd_en}, 32'd0);
    ccsnoopaddr = miss_a; #1;
    chk("miss_ccwrite", {31'd0, ccwrite}, 32'd0);
    cyc(); #1;
    chk("miss_upd_en", {31'd0, upd_en}, 32'd0);
    ccwait = 1'b0; #1;
    chk("miss_busy_drop", {31'd0, snoop_busy}, 32'd0);

    // Invalidate on S frame, then mismatching invalidate.
    ccinv = 1'b1; ccsnoopaddr = hit_a; #1;
    chk("inv_fields", {26'd0, upd_en, upd_index, upd_valid, upd_dirty}, {26'd0, 1'b1, 3'd2, 2'b00});
    chk("inv_busy", {31'd0, snoop_busy}, 32'd1);
    cyc(); ccinv = 1'b0; #1;
    chk("inv_frame_v", {31'd0, fv[2]}, 32'd0);
    load_frame(1'b1, 1'b0, 26'h1A);
    ccinv = 1'b1; ccsnoopaddr = miss_a; #1;
    chk("inv_miss_upd_en", {31'd0, upd_en}, 32'd0);
    cyc(); ccinv = 1'b0;

    // ccinv together with ccwait on an M frame.
    load_frame(1'b1, 1'b1, 26'h1A);
    ccinv = 1'b1; ccwait = 1'b1; ccsnoopaddr = hit_a; #1;
    chk("inv_wait_ccwrite", {31'd0, ccwrite}, 32'd0);
    chk("inv_wait_upd", {30'd0, upd_en, upd_valid}, 32'b10);
    cyc(); ccinv = 1'b0; #1;
    chk("inv_wait_after_ccwrite", {31'd0, ccwrite}, 32'd0);
    cyc(); #1;
    chk("inv_wait_no_wb", daddr, 32'd0);
    ccwait = 1'b0;

    // Reset during WB1 aborts without touching the frame.
    load_frame(1'b1, 1'b1, 26'h1A);
    ccwait = 1'b1; dwait = 1'b0;
    cyc(); cyc(); #1;
    chk("rst_mid_wb1_daddr", daddr, 32'h694);
    RST = 1'b1; ccwait = 1'b0;
    cyc(); #1;
    chk("rst_mid_outs", {ccwrite, upd_en, snoop_busy, 29'd0} | daddr | dstore, 32'd0);
    chk("rst_mid_frame_m", {30'd0, fv[2], fd[2]}, 32'b11);
    RST = 1'b0;
    cyc();
    ccwait = 1'b1; #1;
    chk("rehit_ccwrite", {31'd0, ccwrite}, 32'd1);
    cyc(); #1;
    chk("rehit_wb0_daddr", daddr, 32'h690);
    cyc(); #1;
    chk("rehit_wb1_dstore", dstore, 32'hBBBB0001);
    cyc(); #1;
    chk("rehit_upd", {29'd0, upd_en, upd_valid, upd_dirty}, 32'b110);
    ccwait = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
